// File: rtl/mano_timing_control_unit.sv
// ---------------------------------------------------------------------------
// mano_timing_control_unit
//
// Timing and control sequencer for the Mano basic computer. A 3-bit sequence
// counter (T0..T6) walks each instruction through fetch, decode, the optional
// indirect step and execute. It drives the datapath register strobes, the
// common-bus source select and the memory read/write strobes.
//
// Ports:
//   clk_clock         system clock, rising-edge active
//   RST_N_reset       asynchronous active-low reset
//   START_start       sets the run flag S on the next edge (ignored while running)
//   IR_opcode[2:0]    IR[14:12], sampled only at T2
//   IR_indirect       IR[15], sampled only at T2
//   IR_hlt            IR[0], sampled only at T2, acted on at T3 for opcode 7
//   DR_zero           DR==0 flag, consulted during ISZ T6
//   AR_*/PC_*/DR_*/AC_LD_load/IR_LD_load   register strobes, valid during Tn
//   ALU_sel_select    00 AND, 01 ADD, 10 pass DR
//   MEM_RD_read/MEM_WR_write                memory strobes
//   BUS_SEL_select    1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 MEM, 0 none
//   SC_output         current sequence count
//   RUN_running       run flag S
// ---------------------------------------------------------------------------
module mano_timing_control_unit #(
    parameter int START_AUTO = 0
) (
    input  logic       clk_clock,
    input  logic       RST_N_reset,
    input  logic       START_start,
    input  logic [2:0] IR_opcode,
    input  logic       IR_indirect,
    input  logic       IR_hlt,
    input  logic       DR_zero,
    output logic       AR_LD_load,
    output logic       AR_INR_increment,
    output logic       AR_CLR_clear,
    output logic       PC_LD_load,
    output logic       PC_INR_increment,
    output logic       PC_CLR_clear,
    output logic       DR_LD_load,
    output logic       DR_INR_increment,
    output logic       AC_LD_load,
    output logic [1:0] ALU_sel_select,
    output logic       IR_LD_load,
    output logic       MEM_RD_read,
    output logic       MEM_WR_write,
    output logic [2:0] BUS_SEL_select,
    output logic [2:0] SC_output,
    output logic       RUN_running
);

    localparam logic S_RESET = (START_AUTO != 0);

    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    logic [2:0] sc_reg, sc_next;
    logic       s_reg, s_next;
    logic [2:0] d_reg, d_next;
    logic       i_reg, i_next;
    logic       hlt_reg, hlt_next;

    // State register
    always_ff @(posedge clk_clock or negedge RST_N_reset) begin
        if (!RST_N_reset) begin
            sc_reg  <= 3'd0;
            s_reg   <= S_RESET;
            d_reg   <= 3'd0;
            i_reg   <= 1'b0;
            hlt_reg <= 1'b0;
        end else begin
            sc_reg  <= sc_next;
            s_reg   <= s_next;
            d_reg   <= d_next;
            i_reg   <= i_next;
            hlt_reg <= hlt_next;
        end
    end

    // Next-state logic
    always_comb begin
        sc_next  = sc_reg;
        s_next   = s_reg;
        d_next   = d_reg;
        i_next   = i_reg;
        hlt_next = hlt_reg;
        if (!s_reg) begin
            sc_next = 3'd0;
            if (START_start) begin
                s_next = 1'b1;
            end
        end else begin
            sc_next = sc_reg + 3'd1;
            case (sc_reg)
                3'd2: begin
                    // The IR is stable from T2 on; capture what decode needs.
                    d_next   = IR_opcode;
                    i_next   = IR_indirect;
                    hlt_next = IR_hlt;
                end
                3'd3: begin
                    if (d_reg == OP_REG) begin
                        sc_next = 3'd0;
                        if (hlt_reg) begin
                            s_next = 1'b0;
                        end
                    end
                end
                3'd4: begin
                    if (d_reg == OP_STA || d_reg == OP_BUN) begin
                        sc_next = 3'd0;
                    end
                end
                3'd5: begin
                    if (d_reg != OP_ISZ) begin
                        sc_next = 3'd0;
                    end
                end
                3'd6, 3'd7: begin
                    // T6 only exists for ISZ; T7 is unreachable and recovers.
                    sc_next = 3'd0;
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode; reset gates the strobes so they drop without waiting
    // for the clock.
    always_comb begin
        AR_LD_load       = 1'b0;
        AR_INR_increment = 1'b0;
        PC_LD_load       = 1'b0;
        PC_INR_increment = 1'b0;
        DR_LD_load       = 1'b0;
        DR_INR_increment = 1'b0;
        AC_LD_load       = 1'b0;
        ALU_sel_select   = 2'b00;
        IR_LD_load       = 1'b0;
        MEM_RD_read      = 1'b0;
        MEM_WR_write     = 1'b0;
        BUS_SEL_select   = 3'd0;
        if (RST_N_reset && s_reg) begin
            case (sc_reg)
                3'd0: begin
                    BUS_SEL_select = 3'd2;
                    AR_LD_load     = 1'b1;
                end
                3'd1: begin
                    MEM_RD_read      = 1'b1;
                    BUS_SEL_select   = 3'd7;
                    IR_LD_load       = 1'b1;
                    PC_INR_increment = 1'b1;
                end
                3'd2: begin
                    BUS_SEL_select = 3'd5;
                    AR_LD_load     = 1'b1;
                end
                3'd3: begin
                    if (d_reg != OP_REG && i_reg) begin
                        MEM_RD_read    = 1'b1;
                        BUS_SEL_select = 3'd7;
                        AR_LD_load     = 1'b1;
                    end
                end
                3'd4: begin
                    case (d_reg)
                        3'd0, 3'd1, 3'd2, OP_ISZ: begin
                            MEM_RD_read    = 1'b1;
                            BUS_SEL_select = 3'd7;
                            DR_LD_load     = 1'b1;
                        end
                        OP_STA: begin
                            BUS_SEL_select = 3'd4;
                            MEM_WR_write   = 1'b1;
                        end
                        OP_BUN: begin
                            BUS_SEL_select = 3'd1;
                            PC_LD_load     = 1'b1;
                        end
                        OP_BSA: begin
                            BUS_SEL_select   = 3'd2;
                            MEM_WR_write     = 1'b1;
                            AR_INR_increment = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                3'd5: begin
                    case (d_reg)
                        3'd0, 3'd1, 3'd2: begin
                            AC_LD_load     = 1'b1;
                            ALU_sel_select = d_reg[1:0];
                        end
                        OP_BSA: begin
                            BUS_SEL_select = 3'd1;
                            PC_LD_load     = 1'b1;
                        end
                        OP_ISZ: begin
                            DR_INR_increment = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                3'd6: begin
                    if (d_reg == OP_ISZ) begin
                        BUS_SEL_select   = 3'd3;
                        MEM_WR_write     = 1'b1;
                        PC_INR_increment = DR_zero;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Reserved for a future interrupt cycle.
    assign AR_CLR_clear = 1'b0;
    assign PC_CLR_clear = 1'b0;

    assign SC_output   = sc_reg;
    assign RUN_running = s_reg;

endmodule

// File: tb/tb_mano_timing_control_unit.sv
// ---------------------------------------------------------------------------
// tb_mano_timing_control_unit
//
// Two instances share all inputs: index 0 has START_AUTO=0, index 1 has
// START_AUTO=1. A behavioural model tracks each instance as "position within
// an instruction of known length" and derives the expected outputs from the
// micro-operation rules; a compare process checks every instance on every
// falling edge. Directed scenarios add literal expectations, then a long
// randomized phase exercises arbitrary instruction streams, starts and resets.
// ---------------------------------------------------------------------------
module tb_mano_timing_control_unit;

    typedef struct packed {
        logic       ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr, dr_ld, dr_inr, ac_ld;
        logic [1:0] alu;
        logic       ir_ld, mem_rd, mem_wr;
        logic [2:0] bus;
        logic [2:0] sc;
        logic       run;
    } vec_t;

    logic       clk_clock;
    logic       rst_n;
    logic       start;
    logic [2:0] ir_opcode;
    logic       ir_indirect;
    logic       ir_hlt;
    logic       dr_zero;

    logic [1:0] ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr, dr_ld, dr_inr, ac_ld;
    logic [1:0] ir_ld, mem_rd, mem_wr, run;
    logic [1:0] alu [2];
    logic [2:0] bus [2];
    logic [2:0] sc  [2];
    vec_t       obs [2];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk_clock = 1'b0;
    always #5 clk_clock = ~clk_clock;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            mano_timing_control_unit #(.START_AUTO(gi)) u_dut (
                .clk_clock        (clk_clock),
                .RST_N_reset      (rst_n),
                .START_start      (start),
                .IR_opcode        (ir_opcode),
                .IR_indirect      (ir_indirect),
                .IR_hlt           (ir_hlt),
                .DR_zero          (dr_zero),
                .AR_LD_load       (ar_ld[gi]),
                .AR_INR_increment (ar_inr[gi]),
                .AR_CLR_clear     (ar_clr[gi]),
                .PC_LD_load       (pc_ld[gi]),
                .PC_INR_increment (pc_inr[gi]),
                .PC_CLR_clear     (pc_clr[gi]),
                .DR_LD_load       (dr_ld[gi]),
                .DR_INR_increment (dr_inr[gi]),
                .AC_LD_load       (ac_ld[gi]),
                .ALU_sel_select   (alu[gi]),
                .IR_LD_load       (ir_ld[gi]),
                .MEM_RD_read      (mem_rd[gi]),
                .MEM_WR_write     (mem_wr[gi]),
                .BUS_SEL_select   (bus[gi]),
                .SC_output        (sc[gi]),
                .RUN_running      (run[gi])
            );
            assign obs[gi] = {ar_ld[gi], ar_inr[gi], ar_clr[gi], pc_ld[gi], pc_inr[gi],
                              pc_clr[gi], dr_ld[gi], dr_inr[gi], ac_ld[gi], alu[gi],
                              ir_ld[gi], mem_rd[gi], mem_wr[gi], bus[gi], sc[gi], run[gi]};
        end
    endgenerate

    // ---------------- behavioural model ----------------
    bit m_run [2];
    int m_sc  [2];
    int m_op  [2];
    bit m_ind [2];
    bit m_hlt [2];

    // Number of T-steps each instruction occupies before SC wraps to 0.
    function automatic int instr_len(input int op);
        case (op)
            3, 4:    return 5;
            6:       return 7;
            7:       return 4;
            default: return 6;
        endcase
    endfunction

    always @(posedge clk_clock or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_run[i] <= (i == 1);
                m_sc[i]  <= 0;
                m_op[i]  <= 0;
                m_ind[i] <= 1'b0;
                m_hlt[i] <= 1'b0;
            end else if (!m_run[i]) begin
                if (start) m_run[i] <= 1'b1;
            end else begin
                if (m_sc[i] == 2) begin
                    m_op[i]  <= int'(ir_opcode);
                    m_ind[i] <= ir_indirect;
                    m_hlt[i] <= ir_hlt;
                end
                if (m_sc[i] == 3 && m_op[i] == 7 && m_hlt[i]) m_run[i] <= 1'b0;
                m_sc[i] <= (m_sc[i] + 1 == instr_len(m_op[i])) ? 0 : m_sc[i] + 1;
            end
        end
    end

    function automatic vec_t model_out(input bit ok, input bit mrun, input int msc,
                                       input int op, input bit ind, input bit drz);
        vec_t v;
        v     = '0;
        v.sc  = 3'(msc);
        v.run = mrun;
        if (ok && mrun) begin
            if (msc == 0) begin
                v.bus = 3'd2; v.ar_ld = 1'b1;
            end else if (msc == 1) begin
                v.mem_rd = 1'b1; v.bus = 3'd7; v.ir_ld = 1'b1; v.pc_inr = 1'b1;
            end else if (msc == 2) begin
                v.bus = 3'd5; v.ar_ld = 1'b1;
            end else if (msc == 3) begin
                if (op != 7 && ind) begin
                    v.mem_rd = 1'b1; v.bus = 3'd7; v.ar_ld = 1'b1;
                end
            end else begin
                // Operand read into DR for AND/ADD/LDA/ISZ
                if (msc == 4 && (op <= 2 || op == 6)) begin
                    v.mem_rd = 1'b1; v.bus = 3'd7; v.dr_ld = 1'b1;
                end
                // ALU select equals the opcode for AND/ADD/LDA
                if (msc == 5 && op <= 2) begin
                    v.ac_ld = 1'b1; v.alu = 2'(op);
                end
                if (op == 3 && msc == 4) begin v.bus = 3'd4; v.mem_wr = 1'b1; end
                if (op == 4 && msc == 4) begin v.bus = 3'd1; v.pc_ld  = 1'b1; end
                if (op == 5 && msc == 4) begin v.bus = 3'd2; v.mem_wr = 1'b1; v.ar_inr = 1'b1; end
                if (op == 5 && msc == 5) begin v.bus = 3'd1; v.pc_ld  = 1'b1; end
                if (op == 6 && msc == 5) v.dr_inr = 1'b1;
                if (op == 6 && msc == 6) begin v.bus = 3'd3; v.mem_wr = 1'b1; v.pc_inr = drz; end
            end
        end
        return v;
    endfunction

    function automatic vec_t strip(input vec_t v);
        vec_t r;
        r     = v;
        r.sc  = 3'd0;
        r.run = 1'b0;
        return r;
    endfunction

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk_clock);
            for (int i = 0; i < 2; i++) begin
                vec_t e;
                e = model_out(rst_n, m_run[i], m_sc[i], m_op[i], m_ind[i], dr_zero);
                n_tests++;
                if (obs[i] !== e) begin
                    n_fail++;
                    $display("FAIL cycle_compare dut%0d t=%0t: got %h expected %h", i, $time, obs[i], e);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    vec_t rec [8];

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic start_pulse();
        @(posedge clk_clock); #1;
        start = 1'b1;
        @(posedge clk_clock); #1;
        start = 1'b0;
    endtask

    // Returns at the falling edge of the next T0 of instance 0.
    task automatic wait_t0();
        bit found;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk_clock);
            if (obs[0].sc == 3'd0 && obs[0].run) found = 1'b1;
        end
        chk("wait_t0_timeout", int'(found), 1);
    endtask

    // Called at the falling edge of T0; records T0..T7 of instance 0.
    task automatic run_instr(input logic [2:0] op, input logic ind, input logic hlt,
                             input logic drz, input bit chg_at4);
        rec[0] = obs[0];
        @(posedge clk_clock); #1;
        ir_opcode   = op;
        ir_indirect = ind;
        ir_hlt      = hlt;
        dr_zero     = drz;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk_clock);
            rec[k] = obs[0];
            if (chg_at4 && k == 4) begin
                #1 ir_opcode = 3'd2;
            end
        end
        $display("[TB] instr op=%0d I=%0d hlt=%0d drz=%0d sc=%0d%0d%0d%0d%0d%0d%0d%0d",
                 op, ind, hlt, drz, rec[0].sc, rec[1].sc, rec[2].sc, rec[3].sc,
                 rec[4].sc, rec[5].sc, rec[6].sc, rec[7].sc);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sc_seq [7];
        bit hold_rst;
        sc_seq = '{0, 1, 2, 3, 4, 5, 0};

        rst_n       = 1'b1;
        start       = 1'b0;
        ir_opcode   = 3'd0;
        ir_indirect = 1'b0;
        ir_hlt      = 1'b0;
        dr_zero     = 1'b0;
        #1 rst_n = 1'b0;
        #11 rst_n = 1'b1;

        // Idle with no START: everything stays at zero.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_clock);
            chk("idle_all_zero", int'(obs[0]), 0);
        end

        start_pulse();
        @(negedge clk_clock);
        chk("start_sc", int'(obs[0].sc), 0);
        chk("start_run", int'(obs[0].run), 1);
        chk("start_ar_ld", int'(obs[0].ar_ld), 1);
        chk("start_bus", int'(obs[0].bus), 2);

        // ADD direct
        run_instr(3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) chk("add_sc_seq", int'(rec[k].sc), sc_seq[k]);
        chk("add_t3_idle", int'(strip(rec[3])), 0);
        chk("add_t4_mem_rd", int'(rec[4].mem_rd), 1);
        chk("add_t4_bus", int'(rec[4].bus), 7);
        chk("add_t4_dr_ld", int'(rec[4].dr_ld), 1);
        chk("add_t5_alu", int'(rec[5].alu), 1);
        chk("add_t5_ac_ld", int'(rec[5].ac_ld), 1);

        // STA indirect
        wait_t0();
        run_instr(3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sta_t3_mem_rd", int'(rec[3].mem_rd), 1);
        chk("sta_t3_bus", int'(rec[3].bus), 7);
        chk("sta_t3_ar_ld", int'(rec[3].ar_ld), 1);
        chk("sta_t4_bus", int'(rec[4].bus), 4);
        chk("sta_t4_mem_wr", int'(rec[4].mem_wr), 1);
        chk("sta_wrap_sc", int'(rec[5].sc), 0);

        // ISZ with DR reaching zero, then not
        wait_t0();
        run_instr(3'd6, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("isz1_t6_sc", int'(rec[6].sc), 6);
        chk("isz1_t6_pc_inr", int'(rec[6].pc_inr), 1);
        chk("isz1_t6_mem_wr", int'(rec[6].mem_wr), 1);
        chk("isz1_t6_bus", int'(rec[6].bus), 3);
        chk("isz1_wrap_sc", int'(rec[7].sc), 0);
        wait_t0();
        run_instr(3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("isz0_t6_pc_inr", int'(rec[6].pc_inr), 0);
        chk("isz0_t6_mem_wr", int'(rec[6].mem_wr), 1);
        chk("isz0_t6_bus", int'(rec[6].bus), 3);

        // HLT; opcode change after halting must not matter
        wait_t0();
        run_instr(3'd7, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("hlt_t3_sc", int'(rec[3].sc), 3);
        chk("hlt_t3_idle", int'(strip(rec[3])), 0);
        chk("hlt_t4_run", int'(rec[4].run), 0);
        chk("hlt_t4_sc", int'(rec[4].sc), 0);
        chk("hlt_t7_all_zero", int'(rec[7]), 0);

        // BSA interrupted by reset at T4
        start_pulse();
        @(negedge clk_clock);
        @(posedge clk_clock); #1;
        ir_opcode   = 3'd5;
        ir_indirect = 1'b0;
        ir_hlt      = 1'b0;
        repeat (4) @(negedge clk_clock);
        chk("bsa_t4_sc", int'(obs[0].sc), 4);
        chk("bsa_t4_ar_inr", int'(obs[0].ar_inr), 1);
        chk("bsa_t4_mem_wr", int'(obs[0].mem_wr), 1);
        chk("bsa_t4_bus", int'(obs[0].bus), 2);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_strobes0", int'(strip(obs[0])), 0);
        chk("rst_sc0", int'(obs[0].sc), 0);
        chk("rst_strobes1", int'(strip(obs[1])), 0);
        chk("rst_run1", int'(obs[1].run), 1);
        @(posedge clk_clock); #2;
        rst_n = 1'b1;
        @(negedge clk_clock);
        chk("auto_restart_sc", int'(obs[1].sc), 0);
        chk("auto_restart_ar_ld", int'(obs[1].ar_ld), 1);
        chk("auto_restart_bus", int'(obs[1].bus), 2);
        chk("noauto_run", int'(obs[0].run), 0);
        $display("[TB] directed reset during BSA T4 done");

        // Randomized instruction streams, starts and resets
        hold_rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            @(posedge clk_clock); #1;
            if (hold_rst) begin
                rst_n    = 1'b1;
                hold_rst = 1'b0;
            end
            ir_opcode   = 3'($urandom_range(0, 7));
            ir_indirect = 1'($urandom_range(0, 1));
            ir_hlt      = ($urandom_range(0, 3) == 0);
            dr_zero     = 1'($urandom_range(0, 1));
            start       = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 199);
            if (r == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end else if (r == 1) begin
                rst_n    = 1'b0;
                hold_rst = 1'b1;
            end
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk_clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
